// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse receiver: FSM states, ASCII codes, symbol values.
package morse_pkg;
  typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;

  localparam logic [7:0] NONE        = 8'h00;
  localparam logic [7:0] UNKNOWN     = 8'h3F;
  localparam logic       DOT         = 1'b0;
  localparam logic       DASH        = 1'b1;
  localparam logic [2:0] MAX_SYMBOLS = 3'd5;
endpackage

// File: rtl/morse_if.sv
// Keyed line in, decoded character out; the receiver is the slave side.
interface morse_if;
  logic       in;
  logic [7:0] out;

  modport master (output in, input out);
  modport slave  (input in, output out);
endinterface

// File: rtl/morse_lut.sv
// Combinational decode of {len, pattern} to ASCII, first symbol in the MSB of the len-bit field.
// Zero latency; no flow control.
module morse_lut
  import morse_pkg::*;
(
  input  logic [2:0] len,
  input  logic [4:0] pattern,
  output logic [7:0] ascii
);
  logic [4:0] mask;
  logic [7:0] key;

  // Only the low len bits of pattern carry symbols.
  assign mask = 5'h1F >> (3'd5 - len);
  assign key  = {len, pattern & mask};

  always_comb begin
    ascii = UNKNOWN;
    case (key)
      8'b001_00000: ascii = 8'h45;
      8'b001_00001: ascii = 8'h54;
      8'b010_00000: ascii = 8'h49;
      8'b010_00001: ascii = 8'h41;
      8'b010_00010: ascii = 8'h4E;
      8'b010_00011: ascii = 8'h4D;
      8'b011_00000: ascii = 8'h53;
      8'b011_00001: ascii = 8'h55;
      8'b011_00010: ascii = 8'h52;
      8'b011_00011: ascii = 8'h57;
      8'b011_00100: ascii = 8'h44;
      8'b011_00101: ascii = 8'h4B;
      8'b011_00110: ascii = 8'h47;
      8'b011_00111: ascii = 8'h4F;
      8'b100_00000: ascii = 8'h48;
      8'b100_00001: ascii = 8'h56;
      8'b100_00010: ascii = 8'h46;
      8'b100_00100: ascii = 8'h4C;
      8'b100_00110: ascii = 8'h50;
      8'b100_00111: ascii = 8'h4A;
      8'b100_01000: ascii = 8'h42;
      8'b100_01001: ascii = 8'h58;
      8'b100_01010: ascii = 8'h43;
      8'b100_01011: ascii = 8'h59;
      8'b100_01100: ascii = 8'h5A;
      8'b100_01101: ascii = 8'h51;
      8'b101_11111: ascii = 8'h30;
      8'b101_01111: ascii = 8'h31;
      8'b101_00111: ascii = 8'h32;
      8'b101_00011: ascii = 8'h33;
      8'b101_00001: ascii = 8'h34;
      8'b101_00000: ascii = 8'h35;
      8'b101_10000: ascii = 8'h36;
      8'b101_11000: ascii = 8'h37;
      8'b101_11100: ascii = 8'h38;
      8'b101_11110: ascii = 8'h39;
      default:      ascii = UNKNOWN;
    endcase
  end
endmodule

// File: rtl/morse.sv
// Morse receiver: times mark pulses into dots/dashes, decodes after CHAR_GAP low cycles.
// out updates one edge after the CHAR_GAP-th low sample; no backpressure, out simply holds.
module morse #(
  parameter int DOT_MAX  = 2,
  parameter int CHAR_GAP = 3,
  parameter int CNT_W    = 8
) (
  input  logic   clk,
  input  logic   reset,
  morse_if.slave bus
);
  import morse_pkg::*;

  localparam logic [CNT_W-1:0] DOT_LIM = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(CHAR_GAP);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [4:0]       pattern;
  logic [2:0]       len;
  logic             ovf;
  logic             sym;
  logic [7:0]       ascii;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + ONE;
  assign sym     = (cnt <= DOT_LIM) ? DOT : DASH;

  morse_lut u_lut (
    .len     (len),
    .pattern (pattern),
    .ascii   (ascii)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pattern <= '0;
      len     <= '0;
      ovf     <= 1'b0;
      bus.out <= NONE;
    end else begin
      case (state)
        IDLE: begin
          // if() sends an unknown line level down the low branch
          if (bus.in) begin
            state <= MARK;
            cnt   <= ONE;
          end
        end
        MARK: begin
          if (bus.in) begin
            cnt <= cnt_inc;
          end else begin
            pattern <= {pattern[3:0], sym};
            if (len == MAX_SYMBOLS) ovf <= 1'b1;
            else                    len <= len + 3'd1;
            cnt   <= ONE;
            state <= (ONE >= GAP_LIM) ? EMIT : SPACE;
          end
        end
        SPACE: begin
          if (bus.in) begin
            state <= MARK;
            cnt   <= ONE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc >= GAP_LIM) state <= EMIT;
          end
        end
        EMIT: begin
          bus.out <= ovf ? UNKNOWN : ascii;
          pattern <= '0;
          len     <= '0;
          ovf     <= 1'b0;
          // a mark arriving now is the first cycle of the next character
          if (bus.in) begin
            state <= MARK;
            cnt   <= ONE;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_morse.sv
// Directed bench for the Morse receiver with hand-computed characters.
module tb_morse;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  morse_if bus ();

  morse #(.DOT_MAX(2), .CHAR_GAP(3), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in = v;
      @(posedge clk);
      #1;
    end
  endtask

  // dot = 2 high cycles, dash = 4, each followed by one low cycle
  task automatic sym(input logic dash);
    step(1'b1, dash ? 4 : 2);
    step(1'b0, 1);
  endtask

  // three more lows: 3rd low overall moves to EMIT, 4th edge loads out
  task automatic end_char();
    step(1'b0, 3);
  endtask

  initial begin
    bus.in = 1'b0;
    reset  = 1'b0;
    #1;
    check("reset_async", bus.out, 8'h00);
    step(1'b0, 2);
    check("reset_hold", bus.out, 8'h00);
    reset = 1'b1;
    step(1'b0, 10);
    check("idle_low", bus.out, 8'h00);

    // E: 2 high, 3 low -> EMIT, out loads on the following edge
    step(1'b1, 2);
    step(1'b0, 3);
    check("e_before_emit", bus.out, 8'h00);
    step(1'b0, 1);
    check("e", bus.out, 8'h45);

    step(1'b1, 4);
    step(1'b0, 4);
    check("t", bus.out, 8'h54);

    for (int i = 0; i < 4; i++) sym(1'b0);
    check("five_partial", bus.out, 8'h54);
    sym(1'b0);
    end_char();
    check("five", bus.out, 8'h35);

    sym(1'b0); sym(1'b1);
    end_char();
    check("a", bus.out, 8'h41);

    sym(1'b1); sym(1'b0); sym(1'b1); sym(1'b0);
    end_char();
    check("c", bus.out, 8'h43);

    for (int i = 0; i < 6; i++) sym(1'b0);
    end_char();
    check("overflow", bus.out, 8'h3F);

    sym(1'b0); sym(1'b1);
    check("mid_char", bus.out, 8'h3F);
    sym(1'b0); sym(1'b1);
    end_char();
    check("unassigned", bus.out, 8'h3F);

    // E whose EMIT cycle sees in=1: that cycle starts a 3-cycle mark (dash -> T)
    sym(1'b0);
    step(1'b0, 2);
    step(1'b1, 1);
    check("e_overlap", bus.out, 8'h45);
    step(1'b1, 2);
    step(1'b0, 4);
    check("emit_first_mark", bus.out, 8'h54);

    sym(1'b0);
    end_char();
    check("e_again", bus.out, 8'h45);

    // reset in the middle of a mark clears out without waiting for an edge
    step(1'b1, 2);
    reset = 1'b0;
    #2;
    check("reset_mid_pulse", bus.out, 8'h00);
    step(1'b1, 2);
    reset = 1'b1;
    step(1'b0, 5);
    check("no_emit_after_reset", bus.out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
